ahb_lite_sram_slave: RTL

Parametrised AHB-Lite slave SRAM, the next generation of the memory slave exercised by the layered AHB-Lite testbench. It adds configurable data width and depth, byte/halfword/word write strobing from `hsize`, and read-after-write forwarding. It also adds a two-cycle ERROR response for illegal transfers and optional programmable wait states. It sits on the AHB-Lite bus behind the address decoder (`hsel`) and is driven and monitored through the team's `mem_intf` signal set.

---
 rtl/ahb_lite_sram_slave.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: hsize byte strobes, read-after-write forwarding, two-cycle ERROR response.
// Define AHB_SRAM_WAIT_EN to insert WAIT_CYCLES wait states into every legal data phase.
//
// state | meaning
// IDLE  | no data phase outstanding
// DATA  | legal data phase; completes when the wait count is exhausted
// ERR1  | first ERROR cycle (hready low)
// ERR2  | second ERROR cycle (hready high); accepts the next transfer like IDLE

module ahb_lite_sram_slave #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int RW          = 2,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [3:0]    hprot,
    input  logic [DW-1:0] hwdata,
    input  logic          error,
    output logic [DW-1:0] hrdata,
    output logic          hready,
    output logic [RW-1:0] hresp
);

    localparam int NB     = DW / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int MEM_AW = OFF_W + IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t state, state_nxt;

    logic [DW-1:0]    mem [DEPTH];
    logic             accept;
    logic             a_legal;
    logic             a_oob;
    logic             a_misalign;
    logic [IDX_W-1:0] a_idx;
    logic [NB-1:0]    a_lanes;
    logic             d_write;
    logic [IDX_W-1:0] d_idx;
    logic [NB-1:0]    d_lanes;
    logic             done;
    logic             commit;
    logic             rd_late;
    logic [DW-1:0]    wr_word;
    logic [DW-1:0]    rd_word;
    int               lane_lo;
    int               lane_hi;
    logic             unused_ok;

    assign accept = hready & hsel & htrans[1];
    assign a_idx  = haddr[OFF_W +: IDX_W];
    assign a_oob  = |(haddr >> MEM_AW);

    always_comb begin
        a_misalign = 1'b0;
        for (int i = 0; i < OFF_W; i++) begin
            if (i < int'(hsize)) a_misalign = a_misalign | haddr[i];
        end
        lane_lo = int'(haddr[OFF_W-1:0]);
        lane_hi = lane_lo + (1 << int'(hsize));
        a_lanes = '0;
        for (int i = 0; i < NB; i++) begin
            if (i >= lane_lo && i < lane_hi) a_lanes[i] = 1'b1;
        end
        a_legal = !a_oob && (int'(hsize) <= OFF_W) && !a_misalign && !error;
    end

`ifdef AHB_SRAM_WAIT_EN
    localparam logic [3:0] WAIT_INIT    = 4'(WAIT_CYCLES);
    localparam bit         RD_AT_ACCEPT = (WAIT_CYCLES == 0);

    logic [3:0] wait_cnt;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            wait_cnt <= '0;
        end else if (accept && a_legal) begin
            wait_cnt <= WAIT_INIT;
        end else if (state == S_DATA && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    assign done    = (state == S_DATA) && (wait_cnt == '0);
    // Read data is fetched on the edge entering the final (hready high) cycle.
    assign rd_late = (state == S_DATA) && (wait_cnt == 4'd1) && !d_write;
    assign unused_ok = ^{hburst, hprot, htrans[0]};
`else
    localparam bit RD_AT_ACCEPT = 1'b1;

    assign done    = (state == S_DATA);
    assign rd_late = 1'b0;
    assign unused_ok = ^{hburst, hprot, htrans[0], 4'(WAIT_CYCLES)};
`endif

    assign commit = done && d_write && !hreset;

    always_comb begin
        wr_word = mem[d_idx];
        for (int i = 0; i < NB; i++) begin
            if (d_lanes[i]) wr_word[8*i +: 8] = hwdata[8*i +: 8];
        end
        // A read accepted on the edge its target word is being written sees the merged word.
        rd_word = (commit && d_idx == a_idx) ? wr_word : mem[a_idx];
    end

    always_ff @(posedge hclk) begin
        if (commit) mem[d_idx] <= wr_word;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            d_write <= 1'b0;
            d_idx   <= '0;
            d_lanes <= '0;
        end else if (accept) begin
            d_write <= hwrite & a_legal;
            d_idx   <= a_idx;
            d_lanes <= a_lanes;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            hrdata <= '0;
        end else if (RD_AT_ACCEPT && accept && a_legal && !hwrite) begin
            hrdata <= rd_word;
        end else if (rd_late) begin
            hrdata <= mem[d_idx];
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR2: begin
                if (accept) state_nxt = a_legal ? S_DATA : S_ERR1;
                else        state_nxt = S_IDLE;
            end
            S_DATA: begin
                if (done) begin
                    if (accept) state_nxt = a_legal ? S_DATA : S_ERR1;
                    else        state_nxt = S_IDLE;
                end
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign hready = !((state == S_ERR1) || (state == S_DATA && !done));

    always_comb begin
        hresp    = '0;
        hresp[0] = (state == S_ERR1) || (state == S_ERR2);
    end

endmodule
